fifo_wr_arb: RTL and testbench
==============================

// Module: fifo_wr_arb
// PURPOSE
//  Round-robin arbiter that shares the single write port of a FIFO (w_sig/w_data/full) among NREQ requesters.
//  Grants are burst-locked: an owner keeps the port for up to MAX_BURST beats, then the port rotates.
//  Sits between producer blocks and the FIFO write side, in the FIFO write-clock domain.
// PARAMETERS
//  NREQ      4  number of requesters (>=2)
//  DW        8  data width, matches FIFO w_data
//  MAX_BURST 4  max beats per grant before forced rotation (>=1)
// PORTS
//  clk        in   1         write-side clock; all state on posedge
//  rst        in   1         asynchronous reset, active-high
//  req        in   NREQ      req[i]=1: requester i has a beat on req_data[i]; held until gnt[i]
//  req_data   in   NREQ*DW   packed data; slice i = req_data[i*DW +: DW]
//  gnt        out  NREQ      one-hot beat-accept pulse; requester may change data next cycle
//  fifo_full  in   1         FIFO full flag
//  fifo_w_sig out  1         FIFO write strobe
//  fifo_w_data out DW        FIFO write data
//  owner      out  clog2(NREQ) current owner index (registered)
//  busy       out  1         1 while in BURST state
// BEHAVIOUR
//  - Reset: state=IDLE, owner=0, beat_cnt=0, rr_last=NREQ-1 (req0 is first priority); gnt=0, fifo_w_sig=0, fifo_w_data=0, busy=0.
//  - FSM states IDLE, BURST. Registers: state, owner, beat_cnt (clog2(MAX_BURST+1) bits), rr_last.
//  - rr pick: first i with req[i]=1, scanning rr_last+1, rr_last+2, ... modulo NREQ. The index rr_last is scanned last.
//  - IDLE: if |req, the next state is BURST, owner=pick, beat_cnt=0. Otherwise stay IDLE. No writes in IDLE, giving 1-cycle arbitration latency.
//  - BURST, combinational: fifo_w_sig = req[owner] & ~fifo_full.
//    fifo_w_data = req_data slice [owner], driven to 0 when fifo_w_sig=0.
//    gnt = fifo_w_sig ? (1<<owner) : 0.
//  - Accepted beat (fifo_w_sig=1): beat_cnt+1.
//  - Burst end condition: (accepted && beat_cnt==MAX_BURST-1) || !req[owner].
//  - At burst end: rr_last<=owner.
//    If |req (masked with rr_last=owner): BURST with owner=pick, beat_cnt=0, with no bubble cycle.
//    Otherwise: IDLE.
//  - If the owner is the sole requester at a count-end, it regains the port with a fresh burst.
//  - fifo_full=1 in BURST: no write, no gnt, beat_cnt and owner held. No timeout; the owner waits.
//  - An owner dropping req ends its burst in that cycle, with no write.
//  - Requester dropping req without gnt is allowed: that beat is withdrawn.
//  - Non-owner req changes in BURST are ignored until burst end.
//  - Reset mid-burst: immediate return to reset values. A partial burst is not resumed.
//  - Never more than one gnt bit set. Never more than one write per cycle.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined: adds ports stall_cnt out 16 and beat_cnt_tot out 16.
//    stall_cnt counts BURST cycles with req[owner]&fifo_full.
//    beat_cnt_tot counts accepted beats.
//    Both saturate at 16'hFFFF and reset to 0.
//  FIFO_ARB_STATS_EN undefined: these ports and counters do not exist. Other behaviour is identical.
// TESTING
//  1 Single requester: rst pulse; req=4'b0001, data0=8'hA5, full=0.
//    -> cycle1 IDLE; cycles 2-5 w_sig=1, w_data=A5, gnt=0001; cycle6 new burst by req0.
//  2 All requesting: req=4'b1111 held continuously.
//    -> owner sequence 0,1,2,3,0, 4 beats each, w_sig never low between bursts.
//  3 Backpressure: fifo_full=1 for 3 cycles after beat 2 of req1.
//    -> w_sig=0, gnt=0 for those cycles; beats 3-4 follow; burst total still 4.
//  4 Early release: req0 drops after 2 beats while req2=1.
//    -> one cycle with w_sig=0, then owner=2 writes; req1=0 is skipped.
//  5 Reset mid-burst: rst in beat 3 of owner 2.
//    -> outputs 0 asynchronously; after release with req=1111 the first owner is 0.
//  6 Stats (FIFO_ARB_STATS_EN defined): test 3 stimulus -> stall_cnt=3, beat_cnt_tot=4 after the burst.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Burst-locked round-robin arbiter sharing one FIFO write port among NREQ producers.
// Optional FIFO_ARB_STATS_EN adds saturating stall / accepted-beat counters.
`timescale 1ns/1ps
module fifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic                     fifo_full,
    output logic                     fifo_w_sig,
    output logic [DW-1:0]            fifo_w_data,
    output logic [$clog2(NREQ)-1:0]  owner,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]              stall_cnt,
    output logic [15:0]              beat_cnt_tot,
`endif
    output logic                     busy
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [OW-1:0]   rr_last_q, rr_last_d;

    logic            own_req;
    logic [DW-1:0]   own_data;
    logic            accept;
    logic            burst_end;
    logic            any_req;

    // First requester strictly after 'last', wrapping; 'last' itself is scanned last.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   last);
        logic          found;
        logic [OW-1:0] pick;
        found = 1'b0;
        pick  = last;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && r[i] && (OW'(i) > last)) begin
                pick  = OW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && r[i] && (OW'(i) <= last)) begin
                pick  = OW'(i);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign any_req = |req;

    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                own_req  = req[i];
                own_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        busy        = (state_q == BURST);
        accept      = busy & own_req & ~fifo_full;
        fifo_w_sig  = accept;
        fifo_w_data = accept ? own_data : '0;
        gnt         = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (accept && (owner_q == OW'(i))) begin
                gnt[i] = 1'b1;
            end
        end
        owner       = owner_q;
    end

    // A burst ends on the last allowed beat or as soon as the owner withdraws;
    // the next owner is chosen in the same cycle so there is no bubble.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        rr_last_d  = rr_last_q;
        burst_end  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = BURST;
                    owner_d    = rr_pick(req, rr_last_q);
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                burst_end = (accept && (beat_cnt_q == CW'(MAX_BURST - 1))) || !own_req;
                if (burst_end) begin
                    rr_last_d  = owner_q;
                    beat_cnt_d = '0;
                    if (any_req) begin
                        owner_d = rr_pick(req, owner_q);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            rr_last_q  <= OW'(NREQ - 1);
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            rr_last_q  <= rr_last_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] beat_tot_q, beat_tot_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, busy & own_req & fifo_full);
        beat_tot_d  = sat_inc(beat_tot_q, accept);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            beat_tot_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            beat_tot_q  <= beat_tot_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign beat_cnt_tot = beat_tot_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed vector table, corner sequences, randomized run against a reference model.
`timescale 1ns/1ps
module tb_fifo_wr_arb;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*DW-1:0]      req_data = '0;
    logic [NREQ-1:0]         gnt;
    logic                    fifo_full = 1'b0;
    logic                    fifo_w_sig;
    logic [DW-1:0]           fifo_w_data;
    logic [1:0]              owner;
    logic                    busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]             stall_cnt;
    logic [15:0]             beat_cnt_tot;
`endif

    fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .fifo_full   (fifo_full),
        .fifo_w_sig  (fifo_w_sig),
        .fifo_w_data (fifo_w_data),
        .owner       (owner),
`ifdef FIFO_ARB_STATS_EN
        .stall_cnt   (stall_cnt),
        .beat_cnt_tot(beat_cnt_tot),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    // Reference model: who owns the port, how many beats it has used, who owned it last.
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_last;
    int m_stall;
    int m_tot;

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_beats = 0;
        m_last  = NREQ - 1;
        m_stall = 0;
        m_tot   = 0;
    endtask

    function automatic int mpick(input logic [3:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (((r >> i) & 4'd1) != 4'd0) return i;
        end
        return last;
    endfunction

    function automatic logic [15:0] model_out(input logic [3:0] r, input logic [31:0] d,
                                              input logic f);
        logic w;
        if (!m_busy) return {1'b0, 2'(m_owner), 4'b0000, 1'b0, 8'h00};
        w = (((r >> m_owner) & 4'd1) != 4'd0) && !f;
        return {1'b1, 2'(m_owner), w ? 4'(1 << m_owner) : 4'b0000, w,
                w ? 8'(d >> (8 * m_owner)) : 8'h00};
    endfunction

    task automatic model_update(input logic [3:0] r, input logic f);
        bit own, w;
        if (!m_busy) begin
            if (r != 4'b0) begin
                m_busy  = 1;
                m_owner = mpick(r, m_last);
                m_beats = 0;
            end
        end else begin
            own = ((r >> m_owner) & 4'd1) != 4'd0;
            w   = own && !f;
            if (own && f && m_stall < 65535) m_stall++;
            if (w && m_tot < 65535) m_tot++;
            if (w) m_beats++;
            if ((w && m_beats == MAX_BURST) || !own) begin
                m_last = m_owner;
                if (r != 4'b0) begin
                    m_owner = mpick(r, m_owner);
                    m_beats = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] g, input logic [15:0] e);
        nchecks++;
        if (g !== e) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, g, e);
        end
    endtask

    task automatic check_int(input string tag, input int g, input int e);
        nchecks++;
        if (g != e) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, g, e);
        end
    endtask

    // Called just after a rising edge: apply inputs, sample mid-cycle, advance one clock.
    task automatic drive_check(input logic [3:0] r, input logic [31:0] d, input logic f,
                               input string tag, output logic [15:0] got);
        req       = r;
        req_data  = d;
        fifo_full = f;
        @(negedge clk);
        got = {busy, owner, gnt, fifo_w_sig, fifo_w_data};
        check16(tag, got, model_out(r, d, f));
        @(posedge clk);
        model_update(r, f);
        #1;
`ifdef FIFO_ARB_STATS_EN
        check_int({tag, "_stall"}, int'(stall_cnt), m_stall);
        check_int({tag, "_tot"}, int'(beat_cnt_tot), m_tot);
`endif
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        fifo_full = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit          pre_rst;
        logic [3:0]  r;
        logic [31:0] d;
        logic        f;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] got;
        int beats;
        model_reset();
        @(posedge clk);
        #1;

        // Single requester: idle cycle, then back-to-back bursts; then withdraw.
        tbl[0]  = '{1'b1, 4'b0001, 32'h0000_00A5, 1'b0, {1'b0, 2'd0, 4'b0000, 1'b0, 8'h00}};
        tbl[1]  = '{1'b0, 4'b0001, 32'h0000_00A5, 1'b0, {1'b1, 2'd0, 4'b0001, 1'b1, 8'hA5}};
        tbl[2]  = '{1'b0, 4'b0001, 32'h0000_00A5, 1'b0, {1'b1, 2'd0, 4'b0001, 1'b1, 8'hA5}};
        tbl[3]  = '{1'b0, 4'b0001, 32'h0000_00A5, 1'b0, {1'b1, 2'd0, 4'b0001, 1'b1, 8'hA5}};
        tbl[4]  = '{1'b0, 4'b0001, 32'h0000_00A5, 1'b0, {1'b1, 2'd0, 4'b0001, 1'b1, 8'hA5}};
        tbl[5]  = '{1'b0, 4'b0001, 32'h0000_00A5, 1'b0, {1'b1, 2'd0, 4'b0001, 1'b1, 8'hA5}};
        tbl[6]  = '{1'b0, 4'b0000, 32'h0000_00A5, 1'b0, {1'b1, 2'd0, 4'b0000, 1'b0, 8'h00}};
        tbl[7]  = '{1'b0, 4'b0000, 32'h0000_00A5, 1'b0, {1'b0, 2'd0, 4'b0000, 1'b0, 8'h00}};
        // Early release: req0 drops after two beats, req1 idle is skipped, req2 takes over.
        tbl[8]  = '{1'b1, 4'b0101, 32'h0022_0011, 1'b0, {1'b0, 2'd0, 4'b0000, 1'b0, 8'h00}};
        tbl[9]  = '{1'b0, 4'b0101, 32'h0022_0011, 1'b0, {1'b1, 2'd0, 4'b0001, 1'b1, 8'h11}};
        tbl[10] = '{1'b0, 4'b0101, 32'h0022_0011, 1'b0, {1'b1, 2'd0, 4'b0001, 1'b1, 8'h11}};
        tbl[11] = '{1'b0, 4'b0100, 32'h0022_0011, 1'b0, {1'b1, 2'd0, 4'b0000, 1'b0, 8'h00}};
        tbl[12] = '{1'b0, 4'b0100, 32'h0022_0011, 1'b0, {1'b1, 2'd2, 4'b0100, 1'b1, 8'h22}};
        tbl[13] = '{1'b0, 4'b0000, 32'h0022_0011, 1'b0, {1'b1, 2'd2, 4'b0000, 1'b0, 8'h00}};

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].pre_rst) do_reset();
            drive_check(tbl[i].r, tbl[i].d, tbl[i].f, $sformatf("vec%0d_model", i), got);
            check16($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // All requesting: owners rotate 0,1,2,3,0 with four beats each and no gaps.
        do_reset();
        drive_check(4'b1111, 32'h4433_2211, 1'b0, "rr_idle", got);
        for (int k = 0; k < 20; k++) begin
            int o;
            o = (k / 4) % 4;
            drive_check(4'b1111, 32'h4433_2211, 1'b0, $sformatf("rr%0d_model", k), got);
            check16($sformatf("rr%0d", k), got,
                    {1'b1, 2'(o), 4'(1 << o), 1'b1, 8'(8'h11 * (o + 1))});
        end

        // Backpressure on requester 1 after its second beat; burst still totals four.
        do_reset();
        beats = 0;
        for (int c = 0; c < 8; c++) begin
            logic f;
            f = (c >= 3 && c <= 5);
            drive_check(4'b0010, 32'h0000_BB00, f, $sformatf("bp%0d_model", c), got);
            if (got[8]) beats++;
            if (f) check16($sformatf("bp_stall%0d", c), {got[15], got[12:8]}, 16'h0020);
        end
        check_int("bp_beats", beats, 4);
`ifdef FIFO_ARB_STATS_EN
        check_int("bp_stall_cnt", int'(stall_cnt), 3);
        check_int("bp_beat_tot", int'(beat_cnt_tot), 4);
`endif
        drive_check(4'b0010, 32'h0000_BB00, 1'b0, "bp_next_model", got);
        check16("bp_next", got, {1'b1, 2'd1, 4'b0010, 1'b1, 8'hBB});

        // Asynchronous reset during beat three of owner 2.
        do_reset();
        for (int c = 0; c < 11; c++)
            drive_check(4'b1111, 32'h4433_2211, 1'b0, $sformatf("mr%0d", c), got);
        req = 4'b1111;
        #2;
        check16("mr_pre", {busy, owner, gnt, fifo_w_sig, fifo_w_data},
                {1'b1, 2'd2, 4'b0100, 1'b1, 8'h33});
        rst = 1'b1;
        #1;
        check16("mr_async", {busy, owner, gnt, fifo_w_sig, fifo_w_data}, 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_check(4'b1111, 32'h4433_2211, 1'b0, "mr_idle", got);
        drive_check(4'b1111, 32'h4433_2211, 1'b0, "mr_first_model", got);
        check16("mr_first", got, {1'b1, 2'd0, 4'b0001, 1'b1, 8'h11});

        // Randomized traffic with random backpressure and withdrawals.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] r;
            r = 4'($urandom) | 4'($urandom);
            if ($urandom_range(0, 15) == 0) r = 4'b0000;
            drive_check(r, $urandom, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", c), got);
            nchecks++;
            if (!$onehot0(got[12:9])) begin
                nerr++;
                $display("FAIL rnd_onehot%0d got=%b exp=onehot0", c, got[12:9]);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
